controle_navegacao: RTL and testbench
=====================================

CONTROLE_NAVEGACAO -- requirements
Module: controle_navegacao

Interface
REQ-001 Parameter DEB_N, default 3: consecutive cycles a raw sensor must differ from its filtered value before the filtered value changes (DEB_N >= 1).
REQ-002 Parameter GIRA_MAX, default 16: maximum cycles in GIRANDO before a fault is declared.
REQ-003 Parameter REMOVE_N, default 8: length in cycles of one removal burst.
REQ-004 Parameter CNT_W, default 8: width of the removal counter.
REQ-005 Ports (name, direction, width, meaning):
- clockc2 in 1: single clock; all logic on the rising edge.
- reset in 1: asynchronous, active-high.
- enable in 1: run request.
- head in 1: front obstacle.
- left in 1: left wall present.
- under in 1: floor loss.
- barreira in 1: debris ahead.
- avancar out 1: drive forward.
- girar out 1: rotate.
- remover out 1: debris tool on.
- falha out 1: sticky fault flag.
- estado out 3: current state code.
- n_removidos out CNT_W: completed removals count.

Function
REQ-006 Each of head/left/under/barreira passes through its own debounce counter; the filtered bit toggles on the DEB_N-th consecutive rising edge where raw != filtered; any edge with raw == filtered clears that counter.
REQ-007 The FSM uses only the filtered bits (h, l, u, b); a raw change held stable reaches estado on edge DEB_N+1.
REQ-008 State codes: STANDBY=000, PROCURANDO=001, ACOMPANHANDO=010, GIRANDO=011, REMOVENDO=100, FALHA=111.
REQ-009 Global priority in every state except FALHA: enable=0 -> STANDBY; else u=1 -> STANDBY; else b=1 -> REMOVENDO (from any state except REMOVENDO); else the per-state rules below.
REQ-010 STANDBY: goes to PROCURANDO when enable=1 and u=0.
REQ-011 PROCURANDO: h=1 -> GIRANDO; else l=1 -> ACOMPANHANDO; else stay.
REQ-012 ACOMPANHANDO: h=1 -> GIRANDO; else l=0 -> PROCURANDO; else stay.
REQ-013 GIRANDO:
- Turn counter clears on entry and increments each cycle.
- h=0 -> ACOMPANHANDO.
- If h=1 and the counter equals GIRA_MAX-1 -> FALHA.
REQ-014 REMOVENDO:
- Removal counter clears on entry and counts REMOVE_N cycles.
- On the last cycle, b=0 -> ACOMPANHANDO and n_removidos increments; b=1 -> counter restarts and the state stays REMOVENDO, with no increment.
REQ-015 FALHA is absorbing; only reset leaves it; enable, u and b are ignored.
REQ-016 Outputs are registered Moore decodes of the state register, updating on the same edge as estado:
- PROCURANDO/ACOMPANHANDO: avancar=1.
- GIRANDO: girar=1.
- REMOVENDO: remover=1.
- STANDBY/FALHA: all three 0.
- falha=1 only in FALHA.
REQ-017 At most one of avancar, girar, remover is 1 in any cycle.
REQ-018 n_removidos saturates at 2^CNT_W-1 and never wraps.
REQ-019 Entering STANDBY aborts any removal in progress without incrementing n_removidos; the turn and removal counters clear.

Reset
REQ-020 reset=1 immediately forces, without a clock edge:
- state STANDBY, estado=000;
- all outputs 0, n_removidos=0;
- filtered sensors 0, all counters 0.
REQ-021 Reset asserted mid-removal or mid-turn has the same effect as REQ-020; after release the FSM resumes from STANDBY per REQ-010 on the first rising edge.

Verification (DEB_N=3, GIRA_MAX=16, REMOVE_N=8 unless stated)
REQ-022 Reset, then enable=1 with all sensors 0 -> estado=001 and avancar=1 after 1 edge.
REQ-023 In PROCURANDO, head=1 for 2 cycles then 0 -> no state change. head held at 1 -> estado=011 and girar=1 on the 4th edge.
REQ-024 head held at 1 in GIRANDO -> estado=111 and falha=1 after 16 cycles, all motion outputs 0. Toggling enable -> no change. Reset -> 000.
REQ-025 barreira=1 filtered in ACOMPANHANDO -> remover=1 for 8 cycles; barreira released before the end -> estado=010 and n_removidos=1. With CNT_W=2, 5 removals -> n_removidos=3.
REQ-026 under and barreira become filtered-1 on the same edge -> estado=000, remover stays 0.
REQ-027 Asynchronous reset pulse between edges during REMOVENDO -> outputs 0 and n_removidos=0 before the next edge.

Source files
------------

// File: rtl/controle_navegacao.sv
// controle_navegacao: wall-following navigation controller with debounced sensors.
//
// Each raw sensor (head, left, under, barreira) is filtered by its own debounce
// counter. The FSM only sees the filtered bits. Motion outputs are registered
// Moore decodes of the next state, so they change on the same edge as estado.
//
// Ports:
//   clockc2     in   clock, rising edge
//   reset       in   asynchronous, active-high
//   enable      in   run request
//   head        in   front obstacle
//   left        in   left wall present
//   under       in   floor loss
//   barreira    in   debris ahead
//   avancar     out  drive forward
//   girar       out  rotate
//   remover     out  debris tool on
//   falha       out  sticky fault flag
//   estado      out  current state code
//   n_removidos out  completed removals, saturating
module controle_navegacao #(
  parameter int unsigned DEB_N    = 3,
  parameter int unsigned GIRA_MAX = 16,
  parameter int unsigned REMOVE_N = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clockc2,
  input  logic             reset,
  input  logic             enable,
  input  logic             head,
  input  logic             left,
  input  logic             under,
  input  logic             barreira,
  output logic             avancar,
  output logic             girar,
  output logic             remover,
  output logic             falha,
  output logic [2:0]       estado,
  output logic [CNT_W-1:0] n_removidos
);

  // Counter widths are clamped to at least one bit so degenerate parameters
  // (e.g. DEB_N = 1) still elaborate.
  localparam int unsigned DebW  = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam int unsigned GiraW = (GIRA_MAX > 1) ? $clog2(GIRA_MAX) : 1;
  localparam int unsigned RemW  = (REMOVE_N > 1) ? $clog2(REMOVE_N) : 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_N - 1);
  localparam logic [GiraW-1:0] GiraLast = GiraW'(GIRA_MAX - 1);
  localparam logic [RemW-1:0]  RemLast  = RemW'(REMOVE_N - 1);

  typedef enum logic [2:0] {
    StStandby      = 3'b000,
    StProcurando   = 3'b001,
    StAcompanhando = 3'b010,
    StGirando      = 3'b011,
    StRemovendo    = 3'b100,
    StFalha        = 3'b111
  } state_e;

  // ---------------------------------------------------------------------------
  // Sensor debounce
  // ---------------------------------------------------------------------------
  // Bit order: 0 head, 1 left, 2 under, 3 barreira.
  logic [3:0]            raw;
  logic [3:0]            filt_q, filt_d;
  logic [3:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;

  assign raw = {barreira, under, left, head};

  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != filt_q[i]) begin
        // The DEB_N-th consecutive disagreeing edge flips the filtered bit;
        // the counter then returns to zero since raw and filtered now agree.
        if (deb_cnt_q[i] == DebLast) begin
          filt_d[i] = raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  always_ff @(posedge clockc2 or posedge reset) begin
    if (reset) begin
      filt_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  logic h, l, u, b;
  assign h = filt_q[0];
  assign l = filt_q[1];
  assign u = filt_q[2];
  assign b = filt_q[3];

  // ---------------------------------------------------------------------------
  // Navigation FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [GiraW-1:0]  turn_q, turn_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              rem_restart;
  logic              rem_done;

  always_comb begin
    state_d     = state_q;
    rem_restart = 1'b0;
    rem_done    = 1'b0;

    if (state_q == StFalha) begin
      state_d = StFalha;
    end else if (!enable || u) begin
      state_d = StStandby;
    end else if (b && (state_q != StRemovendo)) begin
      state_d = StRemovendo;
    end else begin
      case (state_q)
        StStandby: begin
          state_d = StProcurando;
        end
        StProcurando, StAcompanhando: begin
          if (h) begin
            state_d = StGirando;
          end else if (l) begin
            state_d = StAcompanhando;
          end else begin
            state_d = StProcurando;
          end
        end
        StGirando: begin
          if (!h) begin
            state_d = StAcompanhando;
          end else if (turn_q == GiraLast) begin
            state_d = StFalha;
          end
        end
        StRemovendo: begin
          if (rem_q == RemLast) begin
            // Debris still present at the end of a burst: run another burst
            // without crediting a removal.
            if (b) begin
              rem_restart = 1'b1;
            end else begin
              state_d  = StAcompanhando;
              rem_done = 1'b1;
            end
          end
        end
        default: begin
          state_d = StStandby;
        end
      endcase
    end
  end

  // Both counters measure time spent in their own state; any exit (including
  // an abort to STANDBY) leaves them at zero for the next entry.
  always_comb begin
    turn_d = '0;
    if ((state_q == StGirando) && (state_d == StGirando)) begin
      turn_d = turn_q + GiraW'(1);
    end
  end

  always_comb begin
    rem_d = '0;
    if ((state_q == StRemovendo) && (state_d == StRemovendo) && !rem_restart) begin
      rem_d = rem_q + RemW'(1);
    end
  end

  always_comb begin
    n_d = n_q;
    if (rem_done && (n_q != {CNT_W{1'b1}})) begin
      n_d = n_q + CNT_W'(1);
    end
  end

  // Registered Moore outputs decoded from the next state.
  logic avancar_q, avancar_d;
  logic girar_q, girar_d;
  logic remover_q, remover_d;
  logic falha_q, falha_d;

  always_comb begin
    avancar_d = (state_d == StProcurando) || (state_d == StAcompanhando);
    girar_d   = (state_d == StGirando);
    remover_d = (state_d == StRemovendo);
    falha_d   = (state_d == StFalha);
  end

  always_ff @(posedge clockc2 or posedge reset) begin
    if (reset) begin
      state_q   <= StStandby;
      turn_q    <= '0;
      rem_q     <= '0;
      n_q       <= '0;
      avancar_q <= 1'b0;
      girar_q   <= 1'b0;
      remover_q <= 1'b0;
      falha_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      rem_q     <= rem_d;
      n_q       <= n_d;
      avancar_q <= avancar_d;
      girar_q   <= girar_d;
      remover_q <= remover_d;
      falha_q   <= falha_d;
    end
  end

  assign estado      = state_q;
  assign avancar     = avancar_q;
  assign girar       = girar_q;
  assign remover     = remover_q;
  assign falha       = falha_q;
  assign n_removidos = n_q;

endmodule

// File: tb/tb_controle_navegacao.sv
module tb_controle_navegacao;

  localparam int DEB = 3;
  localparam int GMAX = 16;
  localparam int RMAX = 8;

  logic       clockc2;
  logic       reset;
  logic       enable, head, left, under, barreira;
  logic       avancar, girar, remover, falha;
  logic [2:0] estado;
  logic [7:0] n_removidos;
  logic       avancar2, girar2, remover2, falha2;
  logic [2:0] estado2;
  logic [1:0] n_removidos2;

  controle_navegacao u_dut (
    .clockc2     (clockc2),
    .reset       (reset),
    .enable      (enable),
    .head        (head),
    .left        (left),
    .under       (under),
    .barreira    (barreira),
    .avancar     (avancar),
    .girar       (girar),
    .remover     (remover),
    .falha       (falha),
    .estado      (estado),
    .n_removidos (n_removidos)
  );

  controle_navegacao #(.CNT_W(2)) u_dut2 (
    .clockc2     (clockc2),
    .reset       (reset),
    .enable      (enable),
    .head        (head),
    .left        (left),
    .under       (under),
    .barreira    (barreira),
    .avancar     (avancar2),
    .girar       (girar2),
    .remover     (remover2),
    .falha       (falha2),
    .estado      (estado2),
    .n_removidos (n_removidos2)
  );

  initial begin
    clockc2 = 1'b0;
    forever #5 clockc2 = ~clockc2;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: state codes, filtered sensors, time spent in the current
  // state, and removal totals saturating at each instance's counter limit.
  int m_state;
  int m_filt[4];
  int m_run[4];
  int m_age;
  int m_n, m_n2;

  function automatic void model_reset();
    m_state = 0;
    m_age   = 0;
    m_n     = 0;
    m_n2    = 0;
    for (int i = 0; i < 4; i++) begin
      m_filt[i] = 0;
      m_run[i]  = 0;
    end
  endfunction

  function automatic void model_step();
    int raw[4];
    int hh, ll, uu, bb, nxt;
    bit restart;
    raw[0] = int'(head); raw[1] = int'(left); raw[2] = int'(under); raw[3] = int'(barreira);
    hh = m_filt[0]; ll = m_filt[1]; uu = m_filt[2]; bb = m_filt[3];
    nxt = m_state;
    restart = 1'b0;
    if (m_state == 7) nxt = 7;
    else if (enable == 1'b0 || uu == 1) nxt = 0;
    else if (bb == 1 && m_state != 4) nxt = 4;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1 || m_state == 2) nxt = (hh == 1) ? 3 : ((ll == 1) ? 2 : 1);
    else if (m_state == 3) nxt = (hh == 0) ? 2 : ((m_age == GMAX - 1) ? 7 : 3);
    else if (m_state == 4 && m_age == RMAX - 1) begin
      if (bb == 1) restart = 1'b1;
      else begin
        nxt  = 2;
        m_n  = (m_n < 255) ? m_n + 1 : 255;
        m_n2 = (m_n2 < 3) ? m_n2 + 1 : 3;
      end
    end
    if (nxt != m_state || restart) m_age = 0;
    else m_age = m_age + 1;
    m_state = nxt;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_filt[i] = raw[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clockc2 or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs are sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clockc2);
      if (cmp_en) begin
        chk("estado", int'(estado), m_state);
        chk("avancar", int'(avancar), (m_state == 1 || m_state == 2) ? 1 : 0);
        chk("girar", int'(girar), (m_state == 3) ? 1 : 0);
        chk("remover", int'(remover), (m_state == 4) ? 1 : 0);
        chk("falha", int'(falha), (m_state == 7) ? 1 : 0);
        chk("n_removidos", int'(n_removidos), m_n);
        chk("estado_w2", int'(estado2), m_state);
        chk("n_removidos_w2", int'(n_removidos2), m_n2);
        chk("motion_onehot", (int'(avancar) + int'(girar) + int'(remover) <= 1) ? 1 : 0, 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clockc2);
  endtask

  task automatic do_removal();
    barreira = 1'b1;
    step(3);
    barreira = 1'b0;
    step(12);
  endtask

  int cnt;

  initial begin
    reset = 1'b1; enable = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barreira = 1'b0;
    #12;
    chk("rst_estado", int'(estado), 0);
    chk("rst_motion", int'({avancar, girar, remover}), 0);
    chk("rst_falha", int'(falha), 0);
    chk("rst_n", int'(n_removidos), 0);
    @(negedge clockc2);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Start: one edge to PROCURANDO.
    enable = 1'b1;
    step(1);
    chk("start_estado", int'(estado), 1);
    chk("start_avancar", int'(avancar), 1);

    // Two-cycle head glitch is filtered out.
    head = 1'b1;
    step(2);
    head = 1'b0;
    step(1);
    chk("glitch_estado", int'(estado), 1);
    head = 1'b1;
    step(3);
    chk("head_edge3_estado", int'(estado), 1);
    step(1);
    chk("head_edge4_estado", int'(estado), 3);
    chk("head_edge4_girar", int'(girar), 1);

    // Turn timeout: FALHA after 16 cycles in GIRANDO.
    step(15);
    chk("turn15_estado", int'(estado), 3);
    step(1);
    chk("timeout_estado", int'(estado), 7);
    chk("timeout_falha", int'(falha), 1);
    chk("timeout_motion", int'({avancar, girar, remover}), 0);
    enable = 1'b0;
    step(4);
    enable = 1'b1;
    step(4);
    chk("falha_sticky", int'(estado), 7);
    #2 reset = 1'b1;
    #1;
    chk("falha_reset_estado", int'(estado), 0);
    chk("falha_reset_falha", int'(falha), 0);
    head = 1'b0;
    @(negedge clockc2);
    reset = 1'b0;

    // Wall following then one removal burst.
    step(1);
    left = 1'b1;
    step(4);
    chk("follow_estado", int'(estado), 2);
    barreira = 1'b1;
    step(3);
    barreira = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (remover) cnt++;
    end
    chk("burst_len", cnt, 8);
    chk("burst_estado", int'(estado), 2);
    chk("burst_n", int'(n_removidos), 1);
    repeat (4) do_removal();
    chk("five_n", int'(n_removidos), 5);
    chk("five_n_sat2", int'(n_removidos2), 3);

    // under and barreira filtered together: under wins.
    under = 1'b1; barreira = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (remover) cnt++;
    end
    chk("ub_remover", cnt, 0);
    chk("ub_estado", int'(estado), 0);
    under = 1'b0; barreira = 1'b0;
    step(6);
    chk("ub_recover", int'(estado), 2);

    // Asynchronous reset in the middle of a removal.
    barreira = 1'b1;
    step(3);
    barreira = 1'b0;
    step(3);
    chk("mid_rem_remover", int'(remover), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_estado", int'(estado), 0);
    chk("async_motion", int'({avancar, girar, remover}), 0);
    chk("async_n", int'(n_removidos), 0);
    chk("async_n2", int'(n_removidos2), 0);
    @(negedge clockc2);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (head ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 14) == 0)) head = ~head;
      if ($urandom_range(0, 9) == 0) left = ~left;
      if (under ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 69) == 0)) under = ~under;
      if (barreira ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 24) == 0))
        barreira = ~barreira;
      if (enable ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0)) enable = ~enable;
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b1;
      end
      step(1);
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
